// File: rtl/winograd_tile_feeder.sv
// winograd_tile_feeder: turns a raster pixel stream into overlapping 4x4 tiles
// (stride 2) for the Winograd F(2x2,3x3) PE. Four image rows are kept in a
// line buffer; row r lives in slot r mod 4. The block alternates between
// filling rows (FILL) and emitting one tile row (EMIT), so the buffer is
// never read and written in the same phase.
module winograd_tile_feeder #(
  parameter int IMG_WIDTH        = 8,
  parameter int IMG_HEIGHT       = 8,
  parameter int INPUT_TILE_SIZE  = 4,
  parameter int KERNEL_SIZE      = 3,
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int CHANNELS         = 3,
  localparam int TS     = INPUT_TILE_SIZE,
  localparam int STRIDE = INPUT_TILE_SIZE - KERNEL_SIZE + 1,
  localparam int PIX_W  = INPUT_DATA_WIDTH * CHANNELS,
  localparam int TILE_W = TS * TS * PIX_W,
  localparam int TR     = (IMG_HEIGHT - TS) / STRIDE + 1,
  localparam int TC     = (IMG_WIDTH - TS) / STRIDE + 1,
  localparam int TRW    = (TR > 1) ? $clog2(TR) : 1,
  localparam int TCW    = (TC > 1) ? $clog2(TC) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              tile_valid,
  input  logic              tile_ready,
  output logic [TILE_W-1:0] tile_data,
  output logic [TRW-1:0]    tile_row,
  output logic [TCW-1:0]    tile_col,
  output logic              tile_last,
  output logic              frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  typedef enum logic [1:0] {S_FILL, S_EMIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [TRW-1:0]    tr_q, tr_d;
  logic [TCW-1:0]    tc_q, tc_d;
  logic              pix_ready_q, pix_ready_d;
  logic              tile_valid_q, tile_valid_d;
  logic [TILE_W-1:0] tile_data_q, tile_data_d;
  logic [TRW-1:0]    tile_row_q, tile_row_d;
  logic [TCW-1:0]    tile_col_q, tile_col_d;
  logic              tile_last_q, tile_last_d;
  logic              frame_done_q, frame_done_d;

  logic              pix_fire, tile_fire, wr_en, load;
  logic [RW-1:0]     last_row;
  logic [TCW-1:0]    ld_tc;
  logic [TILE_W-1:0] tile_rd;

  // Line buffer: TS slots of one image row each. No reset, contents are
  // only ever read after being written in the same frame.
  logic [PIX_W-1:0]  line_q [TS][IMG_WIDTH];

  assign pix_fire  = pix_valid && pix_ready_q;
  assign tile_fire = tile_valid_q && tile_ready;
  // pix_ready is only high in FILL, so every accepted pixel is a write.
  assign wr_en     = pix_fire;
  // Last image row needed before tile row tr_q can be emitted.
  assign last_row  = RW'(STRIDE * tr_q + TS - 1);
  // Tiles are loaded either on entry to EMIT (column 0) or after a mid-row
  // handshake (next column); no other load source exists.
  assign ld_tc     = (state_q == S_EMIT) ? tc_q + 1'b1 : '0;

  // Tile gather: element (i,j) of tile (tr_q, ld_tc). The final pixel of a
  // fill is written on the same edge the first tile is loaded, so it is
  // forwarded straight from pix_data when it falls inside that tile.
  for (genvar gi = 0; gi < TS; gi++) begin : g_i
    for (genvar gj = 0; gj < TS; gj++) begin : g_j
      logic [1:0]       slot;
      logic [CW-1:0]    col;
      logic [PIX_W-1:0] px;
      assign slot = 2'(STRIDE * tr_q + gi);
      assign col  = CW'(STRIDE * ld_tc + gj);
      assign px   = (wr_en && slot == row_q[1:0] && col == col_q) ? pix_data
                                                                 : line_q[slot][col];
      for (genvar gk = 0; gk < CHANNELS; gk++) begin : g_k
        assign tile_rd[((TS*gi + gj) + TS*TS*gk)*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH] =
          px[gk*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH];
      end
    end
  end

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    tr_d         = tr_q;
    tc_d         = tc_q;
    pix_ready_d  = pix_ready_q;
    tile_valid_d = tile_valid_q;
    tile_data_d  = tile_data_q;
    tile_row_d   = tile_row_q;
    tile_col_d   = tile_col_q;
    tile_last_d  = tile_last_q;
    frame_done_d = 1'b0;
    load         = 1'b0;
    case (state_q)
      S_FILL: begin
        pix_ready_d = 1'b1;
        if (pix_fire) begin
          if (col_q == CW'(IMG_WIDTH - 1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
            if (row_q == last_row) begin
              state_d      = S_EMIT;
              pix_ready_d  = 1'b0;
              tile_valid_d = 1'b1;
              load         = 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_EMIT: begin
        if (tile_fire) begin
          if (tc_q != TCW'(TC - 1)) begin
            tc_d = tc_q + 1'b1;
            load = 1'b1;
          end else if (tr_q != TRW'(TR - 1)) begin
            tr_d         = tr_q + 1'b1;
            tc_d         = '0;
            state_d      = S_FILL;
            tile_valid_d = 1'b0;
            pix_ready_d  = 1'b1;
          end else begin
            state_d      = S_DONE;
            tile_valid_d = 1'b0;
            frame_done_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d     = S_FILL;
        pix_ready_d = 1'b1;
        col_d       = '0;
        row_d       = '0;
        tr_d        = '0;
        tc_d        = '0;
      end
      default: state_d = S_FILL;
    endcase
    if (load) begin
      tile_data_d = tile_rd;
      tile_row_d  = tr_q;
      tile_col_d  = ld_tc;
      tile_last_d = (tr_q == TRW'(TR - 1)) && (ld_tc == TCW'(TC - 1));
    end
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_FILL;
      col_q        <= '0;
      row_q        <= '0;
      tr_q         <= '0;
      tc_q         <= '0;
      pix_ready_q  <= 1'b0;
      tile_valid_q <= 1'b0;
      tile_data_q  <= '0;
      tile_row_q   <= '0;
      tile_col_q   <= '0;
      tile_last_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      tr_q         <= tr_d;
      tc_q         <= tc_d;
      pix_ready_q  <= pix_ready_d;
      tile_valid_q <= tile_valid_d;
      tile_data_q  <= tile_data_d;
      tile_row_q   <= tile_row_d;
      tile_col_q   <= tile_col_d;
      tile_last_q  <= tile_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffer write port.
  always_ff @(posedge clk) begin
    if (wr_en) line_q[row_q[1:0]][col_q] <= pix_data;
  end

  assign pix_ready  = pix_ready_q;
  assign tile_valid = tile_valid_q;
  assign tile_data  = tile_data_q;
  assign tile_row   = tile_row_q;
  assign tile_col   = tile_col_q;
  assign tile_last  = tile_last_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_winograd_tile_feeder.sv
// Bench for winograd_tile_feeder: directed frames of pixel (r,c,k) = 8r+c+64k+off,
// a tile-level reference model (expected tile queue) and a per-cycle monitor.
module tb_winograd_tile_feeder;
  localparam int DW = 8, CH = 3, PIX_W = DW*CH, TILE_W = 16*PIX_W, TR = 3, TC = 3;

  logic clk, reset, pix_valid, pix_ready, tile_valid, tile_ready, tile_last, frame_done;
  logic [PIX_W-1:0]  pix_data;
  logic [TILE_W-1:0] tile_data;
  logic [1:0]        tile_row, tile_col;

  winograd_tile_feeder #(
    .IMG_WIDTH(8), .IMG_HEIGHT(8), .INPUT_TILE_SIZE(4), .KERNEL_SIZE(3),
    .INPUT_DATA_WIDTH(DW), .CHANNELS(CH)
  ) dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .tile_valid(tile_valid), .tile_ready(tile_ready),
    .tile_data(tile_data), .tile_row(tile_row), .tile_col(tile_col),
    .tile_last(tile_last), .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [TILE_W-1:0] act, input logic [TILE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/none expected event", name);
  endtask

  function automatic logic [7:0] pix(input int off, input int r, input int c, input int k);
    return 8'((8*r + c + 64*k + off) & 255);
  endfunction

  function automatic logic [PIX_W-1:0] pix_word(input int off, input int r, input int c);
    logic [PIX_W-1:0] w;
    for (int k = 0; k < CH; k++) w[k*DW +: DW] = pix(off, r, c, k);
    return w;
  endfunction

  function automatic logic [7:0] elem(input logic [TILE_W-1:0] d, input int i, input int j, input int k);
    return d[((4*i + j) + 16*k)*DW +: DW];
  endfunction

  // Reference model: the tiles a frame must produce, in order.
  logic [TILE_W-1:0] exp_data_q[$];
  int                exp_row_q[$], exp_col_q[$];
  bit                exp_last_q[$];

  task automatic push_frame(input int off);
    logic [TILE_W-1:0] d;
    for (int tr = 0; tr < TR; tr++)
      for (int tc = 0; tc < TC; tc++) begin
        d = '0;
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++)
            for (int k = 0; k < CH; k++)
              d[((4*i + j) + 16*k)*DW +: DW] = pix(off, 2*tr + i, 2*tc + j, k);
        exp_data_q.push_back(d);
        exp_row_q.push_back(tr);
        exp_col_q.push_back(tc);
        exp_last_q.push_back(tr == TR-1 && tc == TC-1);
      end
  endtask

  task automatic flush_model();
    exp_data_q.delete();
    exp_row_q.delete();
    exp_col_q.delete();
    exp_last_q.delete();
  endtask

  // Pixel source: 64 pixels in raster order, optional random gaps.
  bit abort = 0;
  task automatic drive_frame(input int off, input bit gaps);
    int p = 0;
    int g = 0;
    bit acc;
    @(posedge clk); #1;
    while (p < 64 && g < 5000 && !abort) begin
      if (gaps && $urandom_range(0, 1) == 0) pix_valid = 1'b0;
      else begin
        pix_valid = 1'b1;
        pix_data  = pix_word(off, p / 8, p % 8);
      end
      @(negedge clk);
      acc = pix_valid && pix_ready;
      @(posedge clk); #1;
      if (acc) p++;
      g++;
    end
    pix_valid = 1'b0;
    if (p < 64 && !abort) fail_now("drive_timeout");
  endtask

  // Tile sink: always ready, except a 5-cycle hold on tile (1,1) when armed.
  bit bp_arm = 0;
  int hold_cnt = 0;
  initial begin
    tile_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bp_arm && tile_valid && tile_row == 2'd1 && tile_col == 2'd1 && hold_cnt < 5) begin
        tile_ready = 1'b0;
        hold_cnt++;
      end else tile_ready = 1'b1;
    end
  end

  // Monitor state.
  int pix_cnt = 0, frames_done = 0, tiles_seen = 0, last_seen = 0;
  int stall_cur = 0, stall11 = -1;
  logic [TILE_W-1:0] cap00, cap12, prev_data;
  logic [5:0] prev_ctl;
  bit exp_tv, exp_rowend, exp_fd, exp_after_fd, prev_stall;

  // Per-cycle compare against the model and the handshake timing rules.
  initial begin
    logic [TILE_W-1:0] e_data;
    int e_row, e_col;
    bit e_last, tv_n, re_n, fd_n;
    exp_tv = 0; exp_rowend = 0; exp_fd = 0; exp_after_fd = 0; prev_stall = 0;
    cap00 = '0; cap12 = '0; prev_data = '0; prev_ctl = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        exp_tv = 0; exp_rowend = 0; exp_fd = 0; exp_after_fd = 0; prev_stall = 0;
        pix_cnt = 0; stall_cur = 0;
      end else begin
        check("ready_excl", pix_ready && tile_valid, 0);
        check("frame_done", frame_done, exp_fd);
        if (exp_tv)       check("tv_after_fill", {tile_valid, pix_ready}, 2'b10);
        if (exp_rowend)   check("row_end", {tile_valid, pix_ready}, 2'b01);
        if (exp_fd)       check("done_ctl", {tile_valid, pix_ready}, 2'b00);
        if (exp_after_fd) check("after_done", {pix_ready, frame_done}, 2'b10);
        if (prev_stall) begin
          check("hold_data", tile_data, prev_data);
          check("hold_ctl", {tile_valid, tile_row, tile_col, tile_last}, prev_ctl);
        end
        tv_n = 0; re_n = 0; fd_n = 0;
        if (pix_valid && pix_ready) begin
          pix_cnt++;
          if (pix_cnt >= 32 && pix_cnt % 16 == 0) tv_n = 1;
        end
        if (tile_valid && tile_ready) begin
          tiles_seen++;
          if (exp_data_q.size() == 0) begin
            fail_now("unexpected_tile");
            e_row = int'(tile_row); e_col = int'(tile_col);
          end else begin
            e_data = exp_data_q.pop_front();
            e_row  = exp_row_q.pop_front();
            e_col  = exp_col_q.pop_front();
            e_last = exp_last_q.pop_front();
            check("tile_data", tile_data, e_data);
            check("tile_pos", {tile_row, tile_col, tile_last}, {2'(e_row), 2'(e_col), e_last});
          end
          check("pix_before_tile", pix_cnt, 8*(2*e_row + 4));
          if (tile_last) last_seen++;
          if (tile_row == 2'd0 && tile_col == 2'd0) cap00 = tile_data;
          if (tile_row == 2'd1 && tile_col == 2'd2) cap12 = tile_data;
          if (tile_row == 2'd1 && tile_col == 2'd1) begin
            stall11 = stall_cur;
            stall_cur = 0;
          end
          if (e_col == TC-1) begin
            if (e_row == TR-1) fd_n = 1;
            else re_n = 1;
          end
        end
        if (tile_valid && !tile_ready && tile_row == 2'd1 && tile_col == 2'd1) stall_cur++;
        if (frame_done) begin
          frames_done++;
          pix_cnt = 0;
        end
        exp_after_fd = exp_fd;
        exp_fd       = fd_n;
        exp_tv       = tv_n;
        exp_rowend   = re_n;
        prev_stall   = tile_valid && !tile_ready;
        prev_data    = tile_data;
        prev_ctl     = {tile_valid, tile_row, tile_col, tile_last};
      end
    end
  end

  task automatic wait_frames(input int target);
    int g = 0;
    while (frames_done < target && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (frames_done < target) fail_now("frame_timeout");
    @(negedge clk);
  endtask

  int fd_base, ts_base;

  initial begin
    reset = 1'b0; pix_valid = 1'b0; pix_data = '0;
    repeat (3) @(negedge clk);
    check("reset_ctl", {pix_ready, tile_valid, tile_row, tile_col, tile_last, frame_done}, 0);
    check("reset_data", tile_data, 0);
    #1 reset = 1'b1;
    #1 check("pix_ready_pre", pix_ready, 0);
    @(negedge clk);
    check("pix_ready_rise", pix_ready, 1);

    // Full frame, continuous input, always-ready sink.
    push_frame(0);
    drive_frame(0, 0);
    wait_frames(1);
    check("s1_tiles", tiles_seen, 9);
    check("s1_last", last_seen, 1);
    check("s1_model_empty", exp_data_q.size(), 0);
    check("t00_e121", elem(cap00, 1, 2, 1), 74);
    check("t00_e332", elem(cap00, 3, 3, 2), 155);
    check("t12_e000", elem(cap12, 0, 0, 0), 20);
    check("t12_e332", elem(cap12, 3, 3, 2), 175);

    // Backpressure on tile (1,1).
    hold_cnt = 0; bp_arm = 1;
    push_frame(0);
    drive_frame(0, 0);
    wait_frames(2);
    bp_arm = 0;
    check("s3_stall_len", stall11, 5);
    check("s3_tiles", tiles_seen, 18);

    // Random input gaps.
    push_frame(0);
    drive_frame(0, 1);
    wait_frames(3);
    check("s4_tiles", tiles_seen, 27);
    check("s4_frames", frames_done, 3);

    // Reset in the middle of tile row 1, then a fresh frame with new data.
    push_frame(0);
    fd_base = frames_done;
    fork
      drive_frame(0, 0);
      begin
        int g = 0;
        while (!(tile_valid && tile_row == 2'd1) && g < 2000) begin
          @(negedge clk);
          g++;
        end
        if (g >= 2000) fail_now("row1_timeout");
        #2 reset = 1'b0;
        #1;
        check("mid_reset_ctl", {pix_ready, tile_valid, tile_row, tile_col, tile_last, frame_done}, 0);
        check("mid_reset_data", tile_data, 0);
        abort = 1;
      end
    join
    abort = 0;
    flush_model();
    @(negedge clk); #1 reset = 1'b1;
    push_frame(3);
    drive_frame(3, 0);
    wait_frames(fd_base + 1);
    check("s5_frames", frames_done, fd_base + 1);
    check("s5_t00_e000", elem(cap00, 0, 0, 0), 3);
    check("s5_t00_e332", elem(cap00, 3, 3, 2), 158);

    // Two frames back to back, second frame = first + 1.
    fd_base = frames_done; ts_base = tiles_seen;
    push_frame(0);
    push_frame(1);
    drive_frame(0, 0);
    drive_frame(1, 0);
    wait_frames(fd_base + 2);
    check("s6_tiles", tiles_seen - ts_base, 18);
    check("s6_t00_e000", elem(cap00, 0, 0, 0), 1);
    check("s6_t00_e332", elem(cap00, 3, 3, 2), 156);
    check("s6_model_empty", exp_data_q.size(), 0);
    repeat (3) @(negedge clk);
    check("s6_frames", frames_done - fd_base, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
